// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only channel between the ID checker and the
// system-ID responder it interrogates.
interface sysid_checker_if;
    logic        address;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address,
        output read,
        input  waitrequest,
        input  readdata
    );

    modport slave (
        input  address,
        input  read,
        output waitrequest,
        output readdata
    );
endinterface

// File: rtl/sysid_checker.sv
// Reads the system-ID and build-timestamp words over Avalon-MM and
// compares them against the values this image was built with.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h00000000,
    parameter logic [31:0] EXPECTED_TS    = 32'h00000000,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    sysid_checker_if.master        avm,
    output logic [31:0]            id_value,
    output logic [31:0]            ts_value,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   id_mismatch,
    output logic                   ts_mismatch,
    output logic                   timeout
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        RD_TS,
        CHECK,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic        pend_q, pend_d;
    logic        read_q, read_d;
    logic        addr_q, addr_d;
    logic [31:0] id_q, id_d;
    logic [31:0] ts_q, ts_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        idm_q, idm_d;
    logic        tsm_q, tsm_d;
    logic        to_q, to_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cnt_inc;
    logic        abort;

    assign cnt_inc = cnt_q + 16'd1;

    // A start is latched for one cycle before the read begins; the
    // latch powers up set when the check should run by itself.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        read_d  = read_q;
        addr_d  = addr_q;
        id_d    = id_q;
        ts_d    = ts_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        idm_d   = idm_q;
        tsm_d   = tsm_q;
        to_d    = to_q;
        cnt_d   = cnt_q;
        abort   = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (pend_q) begin
                    pend_d  = 1'b0;
                    state_d = RD_ID;
                    read_d  = 1'b1;
                    addr_d  = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    idm_d   = 1'b0;
                    tsm_d   = 1'b0;
                    to_d    = 1'b0;
                end else if (start) begin
                    pend_d = 1'b1;
                    done_d = 1'b0;
                    pass_d = 1'b0;
                    idm_d  = 1'b0;
                    tsm_d  = 1'b0;
                    to_d   = 1'b0;
                    cnt_d  = '0;
                end
            end
            RD_ID: begin
                if (!avm.waitrequest) begin
                    id_d    = avm.readdata;
                    addr_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = RD_TS;
                end else if (cnt_inc == TIMEOUT_CYCLES) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RD_TS: begin
                if (!avm.waitrequest) begin
                    ts_d    = avm.readdata;
                    read_d  = 1'b0;
                    addr_d  = 1'b0;
                    state_d = CHECK;
                end else if (cnt_inc == TIMEOUT_CYCLES) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            CHECK: begin
                idm_d   = (id_q != EXPECTED_ID);
                tsm_d   = (ts_q != EXPECTED_TS);
                pass_d  = (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        // Responder stalled too long: give up, keep whatever was captured.
        if (abort) begin
            read_d  = 1'b0;
            addr_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            to_d    = 1'b1;
            pass_d  = 1'b0;
            idm_d   = 1'b0;
            tsm_d   = 1'b0;
            cnt_d   = cnt_inc;
            state_d = DONE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pend_q  <= AUTO_START;
            read_q  <= 1'b0;
            addr_q  <= 1'b0;
            id_q    <= '0;
            ts_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            idm_q   <= 1'b0;
            tsm_q   <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            read_q  <= read_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
            ts_q    <= ts_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            idm_q   <= idm_d;
            tsm_q   <= tsm_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    assign avm.read    = read_q;
    assign avm.address = addr_q;
    assign id_value    = id_q;
    assign ts_value    = ts_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign id_mismatch = idm_q;
    assign ts_mismatch = tsm_q;
    assign timeout     = to_q;

endmodule
